// File: rtl/dff_reg_arbiter_pkg.sv
// Shared types and helpers for the dff_reg_arbiter slice.
// Holds the FSM state encoding and the round-robin search function used by the
// picker. The function works on a fixed 8-wide request vector so every
// NUM_REQ in 2..8 can share it. Callers zero-extend their request vector.
package dff_arb_pkg;

  localparam int MAX_REQ     = 8;
  localparam int MAX_ID_W    = 3;
  localparam int DEF_NUM_REQ = 4;
  localparam int ID_W        = $clog2(DEF_NUM_REQ);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] idx;
  } rr_pick_t;

  // The search starts at (last + 1) mod n and wraps around.
  // Offsets are scanned from farthest to nearest. The nearest requester
  // therefore overwrites the others and becomes the winner.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]  req,
                                       input logic [MAX_ID_W-1:0] last,
                                       input int                  n);
    rr_pick_t r;
    int       cand;
    r.found = 1'b0;
    r.idx   = '0;
    for (int off = MAX_REQ; off >= 1; off--) begin
      if (off <= n) begin
        cand = (int'(last) + off) % n;
        if (req[cand[MAX_ID_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = cand[MAX_ID_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dff_reg_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Given the request vector and the previous winner, this module returns the
// next winner as a one-hot vector and as an index. The found output is low
// when nobody is requesting. In that case onehot is all-zero.
module rr_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic                       found,
  output logic [NUM_REQ-1:0]         onehot,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [MAX_REQ-1:0]  req_ext;
  logic [MAX_ID_W-1:0] last_ext;
  rr_pick_t            pick;

  assign req_ext  = MAX_REQ'(req);
  assign last_ext = MAX_ID_W'(last);

  // Search for the next requester after the previous winner.
  always_comb begin
    pick = rr_pick(req_ext, last_ext, NUM_REQ);
  end

  assign found = pick.found;
  assign idx   = IDW'(pick.idx);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign onehot[gi] = pick.found && (pick.idx == MAX_ID_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/dff_reg_arbiter.sv
// Shared-register controller (top).
// Requesters contend for one DATA_W-bit register. The winner is chosen
// round-robin and its data is loaded with one cycle of latency. A winner that
// also asserts lock keeps ownership for up to MAX_LOCK cycles. A one-cycle
// bubble always follows the end of a lock.
// Optional build macro: DFF_ARB_STATS_EN adds the grant_cnt[15:0] output. It
// is a saturating count of granted cycles.
module dff_reg_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          lock,
  input  logic [NUM_REQ*DATA_W-1:0]   d_in,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [$clog2(NUM_REQ)-1:0]  gnt_id,
  output logic                        busy,
  output logic [DATA_W-1:0]           Q_out,
  output logic [DATA_W-1:0]           Qb_out
`ifdef DFF_ARB_STATS_EN
  ,
  output logic [15:0]                 grant_cnt
`endif
);

  localparam int IDW   = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] MAX_LOCK_C = CNT_W'(MAX_LOCK);

  // Registered state and the next values that feed it.
  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q,   gnt_d;
  logic [IDW-1:0]     id_q,    id_d;
  logic [IDW-1:0]     last_q,  last_d;
  logic               busy_q,  busy_d;
  logic [DATA_W-1:0]  reg_q,   reg_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  // Each requester's data word is unpacked into an array so it can be
  // indexed by the winner.
  logic [DATA_W-1:0]  data_slice [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign data_slice[gi] = d_in[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin winner among the current requests.
  logic               win_found;
  logic [NUM_REQ-1:0] win_onehot;
  logic [IDW-1:0]     win_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req    (req),
    .last   (last_q),
    .found  (win_found),
    .onehot (win_onehot),
    .idx    (win_idx)
  );

  // The lock owner keeps the register only while it holds both req and lock.
  logic owner_hold;
  assign owner_hold = req[id_q] & lock[id_q];

  // Next-state logic. IDLE arbitrates on every cycle. LOCKED serves only the
  // owner until it releases or times out.
  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    id_d    = id_q;
    last_d  = last_q;
    busy_d  = busy_q;
    reg_d   = reg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        cnt_d  = '0;
        if (win_found) begin
          reg_d  = data_slice[win_idx];
          gnt_d  = win_onehot;
          id_d   = win_idx;
          last_d = win_idx;
          if (lock[win_idx]) begin
            state_d = LOCKED;
            cnt_d   = CNT_W'(1);
            busy_d  = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (owner_hold && (cnt_q < MAX_LOCK_C)) begin
          reg_d  = data_slice[id_q];
          gnt_d  = gnt_q;
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
        end else begin
          // Release or timeout: one bubble cycle with no grant. The owner
          // stays the last winner, so it gets lowest priority next time.
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, grant outputs and the shared register. All are cleared on reset.
  // The round-robin pointer restarts at NUM_REQ-1, so requester 0 is first.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      last_q  <= IDW'(NUM_REQ - 1);
      busy_q  <= 1'b0;
      reg_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      reg_q   <= reg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = id_q;
  assign busy   = busy_q;
  assign Q_out  = reg_q;
  // The complement comes from the same flops, so it can never disagree
  // with Q_out.
  assign Qb_out = ~reg_q;

`ifdef DFF_ARB_STATS_EN
  logic [15:0] gcnt_q;

  // Count the cycles that show a grant. The count saturates at all-ones.
  always_ff @(posedge clock) begin
    if (!reset) begin
      gcnt_q <= '0;
    end else if ((|gnt_d) && (gcnt_q != 16'hFFFF)) begin
      gcnt_q <= gcnt_q + 16'd1;
    end
  end

  assign grant_cnt = gcnt_q;
`endif

endmodule
